// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory
// and writeback for a small MIPS-style subset and counts retirements.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ct_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  state_t st;
  logic   is_lw, is_sw, is_r, is_beq, is_j, is_addiu;
  logic   legal, retire;

  assign state    = st;
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_r     = (opcode == OP_R);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_addiu = (opcode == OP_ADDIU);
  assign legal    = is_lw | is_sw | is_r | is_beq | is_j | is_addiu;

  assign retire = (st == MEMWB) | (st == RWB) | (st == BRANCH) |
                  (st == JUMP) | (st == IWB) |
                  ((st == MEMWR) & mem_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= FETCH;
      retired <= '0;
    end else begin
      // Written every cycle so the counter always reflects its own value.
      retired <= retired + {15'd0, retire};
      case (st)
        FETCH:  if (mem_ready) st <= DECODE;
        DECODE: begin
          unique case (1'b1)
            is_lw, is_sw: st <= MEMADR;
            is_r:         st <= REXEC;
            is_beq:       st <= BRANCH;
            is_j:         st <= JUMP;
            is_addiu:     st <= IEXEC;
            default:      st <= FETCH;
          endcase
        end
        MEMADR: st <= is_lw ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) st <= MEMWB;
        MEMWR:  if (mem_ready) st <= FETCH;
        REXEC:  st <= RWB;
        IEXEC:  st <= IWB;
        MEMWB, RWB, BRANCH, JUMP, IWB: st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ct_op     = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    // Everything stays quiet while reset is held.
    if (rst) begin
      case (st)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          illegal   = ~legal;
        end
        MEMADR, IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        REXEC: begin
          alu_src_a = 1'b1;
          alu_ct_op = 2'b10;
        end
        RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ct_op     = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        IWB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-low.
REQ-003 opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-005 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes and mux selects.
REQ-006 alu_src_b  output  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-007 alu_ct_op  output  2  to the ALU control decoder: 00 add, 01 subtract, 10 decode by funct.
REQ-008 pc_source  output  2  PC select: 00 ALU result, 01 ALU-out register, 10 jump target.
REQ-009 state  output  4  current FSM state encoding, for debug.
REQ-010 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-011 retired  output  16  count of completed instructions.

Function
REQ-012 Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12-15 are unused and shall go to FETCH on the next edge.
REQ-013 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addiu 001001.
REQ-014 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ct_op=00, pc_source=00. ir_write and pc_write assert only in a cycle where mem_ready=1. The FSM holds in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_ct_op=00. Next state by opcode:
- lw or sw -> MEMADR
- R-type -> REXEC
- beq -> BRANCH
- j -> JUMP
- addiu -> IEXEC
- any other opcode -> FETCH, with illegal=1 for this cycle.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Next state is MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: mem_read=1, i_or_d=1. The FSM holds while mem_ready=0 and goes to MEMWB when mem_ready=1.
REQ-018 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
REQ-019 MEMWR: mem_write=1, i_or_d=1. The FSM holds while mem_ready=0 and goes to FETCH when mem_ready=1.
REQ-020 REXEC: alu_src_a=1, alu_src_b=00, alu_ct_op=10. Next state is RWB.
REQ-021 RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_write_cond=1, pc_source=01. Next state is FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10. Next state is FETCH.
REQ-024 IEXEC: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Next state is IWB.
REQ-025 IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
REQ-026 Any output not listed for a state shall be 0 in that state.
REQ-027 Outputs are a combinational function of the registered state plus mem_ready only.
REQ-028 retired increments by 1 on the edge leaving MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH, JUMP or IWB.
REQ-029 retired wraps from 0xFFFF to 0x0000. An illegal opcode does not increment it.
REQ-030 Cycle counts with mem_ready tied high:
- lw: 5 cycles
- sw, R-type, addiu: 4 cycles
- beq, j: 3 cycles.
REQ-031 Every cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-032 mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Reset
REQ-033 On a clock edge with rst=0: state <= FETCH and retired <= 0, regardless of the current state or a pending memory access.
REQ-034 While rst=0, all strobe and select outputs and illegal shall be 0.
REQ-035 After rst returns to 1, the first cycle is FETCH with mem_read=1.
REQ-036 Reset asserted during MEMWR shall produce no mem_write in the cycle after the reset edge.

Verification
REQ-037 Reset, then lw with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; retired=1.
REQ-038 R-type, mem_ready=1 -> states 0,1,6,7,0; alu_ct_op=10 in REXEC; reg_dst=1 in RWB.
REQ-039 FETCH with mem_ready low for 3 cycles -> state stays 0 for 4 cycles; ir_write high only in the 4th cycle.
REQ-040 opcode=111111 in DECODE -> illegal pulses for exactly 1 cycle; next state 0; retired unchanged.
REQ-041 Preload retired=0xFFFF via 65535 j instructions, then one more j -> retired=0x0000.
REQ-042 rst=0 for 1 cycle while in MEMWR with mem_ready=0 -> state=0, mem_write=0, retired=0.
